// File: rtl/wavelet_pkg.sv
// Shared constants and types for the wavelet analysis channel.
package wavelet_pkg;

    localparam int BITS_PER_ELEM  = 8;
    localparam int FIR_NUM_ELEM   = 9;
    localparam int ACC_BITS       = 20;
    localparam int SUM_TRUNCATION = 8;

    // Packed signed 8-bit FIR coefficients, coef k = FILTER_VAL[8k+7:8k]
    localparam logic [FIR_NUM_ELEM*BITS_PER_ELEM-1:0] FILTER_VAL = 72'hf6dcc51c7c1cc5dcf6;

    // Output channel select codes
    localparam logic [7:0] SEL_RS      = 8'd0;
    localparam logic [7:0] SEL_WAVELET = 8'd1;
    localparam logic [7:0] SEL_RAW     = 8'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_t;

endpackage

// File: rtl/wavelet_calc_unit_if.sv
// Channel bus: sample inputs, FIR taps/strobes, select and channel outputs.
interface wavelet_calc_unit_if;
    import wavelet_pkg::*;

    logic [BITS_PER_ELEM-1:0]              i_new;
    logic [BITS_PER_ELEM-1:0]              i_old;
    logic                                  i_start_calc;
    logic [FIR_NUM_ELEM*BITS_PER_ELEM-1:0] i_fir_taps;
    logic                                  i_fir_start_calc;
    logic [7:0]                            i_select;
    logic                                  o_shift_in_rdy;
    logic [7:0]                            o_rs;
    logic [7:0]                            o_wavelet;
    logic                                  o_fir_busy;
    logic [7:0]                            o_mux;

    modport master (
        output i_new, i_old, i_start_calc, i_fir_taps, i_fir_start_calc, i_select,
        input  o_shift_in_rdy, o_rs, o_wavelet, o_fir_busy, o_mux
    );

    modport slave (
        input  i_new, i_old, i_start_calc, i_fir_taps, i_fir_start_calc, i_select,
        output o_shift_in_rdy, o_rs, o_wavelet, o_fir_busy, o_mux
    );

endinterface

// File: rtl/fir_mac.sv
// Sequential 9-tap FIR: one multiply-accumulate per clock, then shift and
// reduce to 8 bits. Optional macro FIR_SATURATE_EN clamps the shifted sum
// to [-128, 127]; without it the low 8 bits are taken (wrap-around).
module fir_mac
    import wavelet_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [FIR_NUM_ELEM*BITS_PER_ELEM-1:0] i_taps,
    input  logic                                  i_start,
    output logic [7:0]                            o_wavelet,
    output logic                                  o_busy
);

    fir_state_t                            r_state, w_state_next;
    logic [3:0]                            r_idx, w_idx_next;
    logic signed [ACC_BITS-1:0]            r_acc, w_acc_next;
    logic [7:0]                            r_wavelet, w_wavelet_next;
    logic                                  r_busy, w_busy_next;
    logic                                  w_load;
    logic [FIR_NUM_ELEM*BITS_PER_ELEM-1:0] r_taps;
    logic [7:0]                            w_result;
    logic signed [16:0]                    w_prod;

    logic signed [7:0] w_coef [FIR_NUM_ELEM];
    logic        [7:0] w_tap  [FIR_NUM_ELEM];

    genvar gi;
    generate
        for (gi = 0; gi < FIR_NUM_ELEM; gi++) begin : g_unpack
            assign w_coef[gi] = FILTER_VAL[8*gi +: 8];
            assign w_tap[gi]  = r_taps[8*gi +: 8];
        end
    endgenerate

    // Taps are unsigned, so a zero bit is prepended before the signed multiply
    assign w_prod = 17'(w_coef[r_idx]) * 17'($signed({1'b0, w_tap[r_idx]}));

`ifdef FIR_SATURATE_EN
    localparam int SH_BITS = ACC_BITS - SUM_TRUNCATION;
    localparam logic signed [SH_BITS-1:0] SAT_MAX = 127;
    localparam logic signed [SH_BITS-1:0] SAT_MIN = -128;
    logic signed [SH_BITS-1:0] w_shifted;

    assign w_shifted = SH_BITS'(r_acc >>> SUM_TRUNCATION);

    // Clamp the floor-shifted sum into the signed 8-bit range
    always_comb begin
        w_result = 8'(w_shifted);
        if (w_shifted > SAT_MAX) begin
            w_result = 8'h7f;
        end else if (w_shifted < SAT_MIN) begin
            w_result = 8'h80;
        end
    end
`else
    assign w_result = 8'(r_acc >>> SUM_TRUNCATION);
`endif

    // Capture the tap vector at the start edge so later changes are ignored
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_taps <= i_taps;
        end
    end

    // FSM, index, accumulator and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_acc     <= '0;
            r_wavelet <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_acc     <= w_acc_next;
            r_wavelet <= w_wavelet_next;
            r_busy    <= w_busy_next;
        end
    end

    // Next-state logic: IDLE waits for a start, MAC walks the taps, DONE publishes
    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_acc_next     = r_acc;
        w_wavelet_next = r_wavelet;
        w_busy_next    = r_busy;
        w_load         = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_load       = 1'b1;
                    w_acc_next   = '0;
                    w_idx_next   = '0;
                    w_busy_next  = 1'b1;
                    w_state_next = MAC;
                end
            end
            MAC: begin
                w_acc_next = r_acc + ACC_BITS'(w_prod);
                w_idx_next = r_idx + 4'd1;
                if (r_idx == 4'(FIR_NUM_ELEM - 1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_wavelet_next = w_result;
                w_busy_next    = 1'b0;
                w_state_next   = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign o_wavelet = r_wavelet;
    assign o_busy    = r_busy;

endmodule

// File: rtl/wavelet_calc_unit.sv
// One analysis channel: rolling-sum moving average, sequential FIR (fir_mac)
// and a registered output selector. FIR clamping follows macro FIR_SATURATE_EN.
module wavelet_calc_unit
    import wavelet_pkg::*;
#(
    parameter int NUM_ELEM = 4
)(
    input  logic                clk,
    input  logic                rst,
    wavelet_calc_unit_if.slave  bus
);

    localparam int RS_BITS  = $clog2(NUM_ELEM * 255);
    localparam int RS_SHIFT = $clog2(NUM_ELEM);

    logic [RS_BITS-1:0] r_acc;
    logic [RS_BITS-1:0] w_rs_sum;
    logic [7:0]         r_rs;
    logic               r_rdy;
    logic [7:0]         r_mux;
    logic [7:0]         w_mux_next;
    logic [7:0]         w_wavelet;
    logic               w_fir_busy;

    // Window sum is updated incrementally: add the newest sample, drop the oldest
    assign w_rs_sum = r_acc + RS_BITS'(bus.i_new) - RS_BITS'(bus.i_old);

    // Rolling accumulator and averaged output with a one-cycle ready pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_rs  <= '0;
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= bus.i_start_calc;
            if (bus.i_start_calc) begin
                r_acc <= w_rs_sum;
                r_rs  <= 8'(w_rs_sum >> RS_SHIFT);
            end
        end
    end

    // Channel select decode
    always_comb begin
        w_mux_next = 8'h00;
        case (bus.i_select)
            SEL_RS:      w_mux_next = r_rs;
            SEL_WAVELET: w_mux_next = w_wavelet;
            SEL_RAW:     w_mux_next = bus.i_new;
            default:     w_mux_next = 8'h00;
        endcase
    end

    // Registered output selector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mux <= '0;
        end else begin
            r_mux <= w_mux_next;
        end
    end

    fir_mac u_fir_mac (
        .clk       (clk),
        .rst       (rst),
        .i_taps    (bus.i_fir_taps),
        .i_start   (bus.i_fir_start_calc),
        .o_wavelet (w_wavelet),
        .o_busy    (w_fir_busy)
    );

    assign bus.o_rs           = r_rs;
    assign bus.o_shift_in_rdy = r_rdy;
    assign bus.o_wavelet      = w_wavelet;
    assign bus.o_fir_busy     = w_fir_busy;
    assign bus.o_mux          = r_mux;

endmodule

// File: tb/tb_wavelet_calc_unit.sv
// Self-checking bench for wavelet_calc_unit: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_wavelet_calc_unit;

    localparam int WIN = 4;
    localparam int COEF [9] = '{-10, -36, -59, 28, 124, 28, -59, -36, -10};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wavelet_calc_unit_if bus();

    wavelet_calc_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state
    int         m_win[$];
    logic [7:0] m_rs, m_wav, m_mux, m_pend;
    bit         m_rdy, m_busy;
    int         m_cnt;

    // Driver-side copy of the window, used to supply the leaving sample
    int d_win[$];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h expected=%02h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // FIR result straight from the dot product, floor shift, optional clamp
    function automatic logic [7:0] fir_expect(input logic [71:0] taps);
        int acc;
        int sh;
        acc = 0;
        for (int k = 0; k < 9; k++) begin
            acc += COEF[k] * int'(taps[8*k +: 8]);
        end
        sh = acc >>> 8;
`ifdef FIR_SATURATE_EN
        if (sh > 127)  sh = 127;
        if (sh < -128) sh = -128;
`endif
        return 8'(sh);
    endfunction

    function automatic logic [71:0] make_taps(input logic [8:0] mask);
        logic [71:0] t;
        t = '0;
        for (int k = 0; k < 9; k++) begin
            t[8*k +: 8] = mask[k] ? 8'hFF : 8'h00;
        end
        return t;
    endfunction

    // Reference model: window average, FIR result after a 10-cycle countdown
    always @(posedge clk) begin
        if (rst) begin
            m_win  = '{0, 0, 0, 0};
            m_rs   = 8'h00;
            m_rdy  = 1'b0;
            m_wav  = 8'h00;
            m_busy = 1'b0;
            m_cnt  = 0;
            m_mux  = 8'h00;
            m_pend = 8'h00;
        end else begin : model_step
            int s;
            case (int'(bus.i_select))
                0:       m_mux = m_rs;
                1:       m_mux = m_wav;
                2:       m_mux = bus.i_new;
                default: m_mux = 8'h00;
            endcase
            m_rdy = 1'b0;
            if (bus.i_start_calc) begin
                m_win.push_back(int'(bus.i_new));
                void'(m_win.pop_front());
                s = 0;
                foreach (m_win[i]) s += m_win[i];
                m_rs  = 8'(s / WIN);
                m_rdy = 1'b1;
            end
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_wav  = m_pend;
                    m_busy = 1'b0;
                end
            end else if (bus.i_fir_start_calc) begin
                m_pend = fir_expect(bus.i_fir_taps);
                m_cnt  = 10;
                m_busy = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk8("cyc_o_rs", bus.o_rs, m_rs);
            chk1("cyc_rdy", bus.o_shift_in_rdy, m_rdy);
            chk8("cyc_o_wavelet", bus.o_wavelet, m_wav);
            chk1("cyc_busy", bus.o_fir_busy, m_busy);
            chk8("cyc_o_mux", bus.o_mux, m_mux);
        end
    end

    task automatic rs_push(input logic [7:0] v);
        bus.i_new        = v;
        bus.i_old        = 8'(d_win[0]);
        bus.i_start_calc = 1'b1;
        d_win.push_back(int'(v));
        void'(d_win.pop_front());
    endtask

    task automatic rs_step(input logic [7:0] v, input logic [7:0] exp);
        rs_push(v);
        @(posedge clk); #1;
        bus.i_start_calc = 1'b0;
        chk8("rs_dir", bus.o_rs, exp);
        chk1("rdy_pulse", bus.o_shift_in_rdy, 1'b1);
        @(posedge clk); #1;
        chk1("rdy_drop", bus.o_shift_in_rdy, 1'b0);
        chk8("rs_hold", bus.o_rs, exp);
    endtask

    // Start a FIR run, optionally hammer start/taps while busy, check result
    task automatic fir_run(input logic [71:0] taps, input logic [7:0] exp,
                           input bit restart, input string name);
        bus.i_fir_taps       = taps;
        bus.i_fir_start_calc = 1'b1;
        @(posedge clk); #1;
        chk1("busy_rise", bus.o_fir_busy, 1'b1);
        bus.i_fir_start_calc = restart;
        bus.i_fir_taps       = 72'({$urandom(), $urandom(), $urandom()});
        repeat (3) @(posedge clk);
        #1;
        bus.i_fir_start_calc = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk1("busy_e9", bus.o_fir_busy, 1'b1);
        @(posedge clk); #1;
        chk1("busy_fall", bus.o_fir_busy, 1'b0);
        chk8(name, bus.o_wavelet, exp);
    endtask

    initial begin
        logic [7:0] sel_vals [4];
        logic [7:0] sel_exp  [4];

        bus.i_new            = '0;
        bus.i_old            = '0;
        bus.i_start_calc     = 1'b0;
        bus.i_fir_taps       = '0;
        bus.i_fir_start_calc = 1'b0;
        bus.i_select         = '0;
        d_win                = '{0, 0, 0, 0};
        rst                  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk8("reset_o_rs", bus.o_rs, 8'h00);
        chk8("reset_o_wavelet", bus.o_wavelet, 8'h00);
        chk1("reset_busy", bus.o_fir_busy, 1'b0);
        chk1("reset_rdy", bus.o_shift_in_rdy, 1'b0);
        chk8("reset_o_mux", bus.o_mux, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        // Window fill, then one sample leaves
        rs_step(8'd100, 8'd25);
        rs_step(8'd100, 8'd50);
        rs_step(8'd100, 8'd75);
        rs_step(8'd100, 8'd100);
        rs_step(8'd0,   8'd75);

        // FIR directed cases
        fir_run({9{8'd100}}, 8'hF4, 1'b0, "fir_const");
        fir_run(make_taps(9'b000010000), 8'h7B, 1'b0, "fir_impulse");
`ifdef FIR_SATURATE_EN
        fir_run(make_taps(9'b000111000), 8'h7F, 1'b0, "fir_sat_pos");
        fir_run(make_taps(9'b111000111), 8'h80, 1'b0, "fir_sat_neg");
`else
        fir_run(make_taps(9'b000111000), 8'hB3, 1'b0, "fir_wrap_pos");
        fir_run(make_taps(9'b111000111), 8'h2E, 1'b0, "fir_wrap_neg");
`endif
        // A restart while busy must not disturb the running evaluation
        fir_run({9{8'd100}}, 8'hF4, 1'b1, "fir_restart_ignored");

        // Selector sweep: o_rs=75, o_wavelet=F4, raw sample 5A, other -> 00
        sel_vals = '{8'd0, 8'd1, 8'd2, 8'd7};
        sel_exp  = '{8'd75, 8'hF4, 8'h5A, 8'h00};
        for (int i = 0; i < 4; i++) begin
            bus.i_select = sel_vals[i];
            bus.i_new    = 8'h5A;
            @(posedge clk); #1;
            chk8("sel_sweep", bus.o_mux, sel_exp[i]);
        end

        // Reset sampled on E5 of a running evaluation
        bus.i_fir_taps       = make_taps(9'b111111111);
        bus.i_fir_start_calc = 1'b1;
        @(posedge clk); #1;
        bus.i_fir_start_calc = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        d_win = '{0, 0, 0, 0};
        chk1("rst_mid_busy", bus.o_fir_busy, 1'b0);
        chk8("rst_mid_wavelet", bus.o_wavelet, 8'h00);
        chk8("rst_mid_o_rs", bus.o_rs, 8'h00);
        repeat (12) @(posedge clk);
        #1;
        chk8("rst_no_resume", bus.o_wavelet, 8'h00);

        // Randomized traffic, checked by the per-cycle compare
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                rs_push(8'($urandom()));
            end else begin
                bus.i_start_calc = 1'b0;
                bus.i_new        = 8'($urandom());
            end
            bus.i_fir_start_calc = ($urandom_range(5, 0) == 0);
            bus.i_fir_taps       = 72'({$urandom(), $urandom(), $urandom()});
            bus.i_select         = ($urandom_range(3, 0) == 3) ? 8'($urandom()) :
                                                                8'($urandom_range(2, 0));
            @(posedge clk); #1;
        end

        bus.i_start_calc     = 1'b0;
        bus.i_fir_start_calc = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk1("final_idle", bus.o_fir_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
